dac_spi_serializer: RTL



---
 rtl/dac_spi_serializer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: converts each signed 12-bit filter sample to offset binary
// and shifts it out as a 16-bit frame to an MCP4921-class DAC, then pulses LDAC.
// A one-entry holding register keeps a sample that arrives mid-frame.
//
// Ports:
//   inClk          system clock, all logic on the rising edge
//   inReset        synchronous active-high reset
//   inSample       signed (two's complement) filter output
//   inSampleReady  sample strobe from the filter, may be asynchronous
//   outDacCs       SPI chip select, active low
//   outDacSck      SPI clock, idles low
//   outDacSdi      SPI data, MSB first
//   outDacLdac     DAC latch strobe, active low
//   outBusy        high while a frame (shift, tail or latch) is in progress
//   outOverrun     one-cycle pulse when a pending sample is overwritten
module dac_spi_serializer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [3:0]  DAC_CONFIG = 4'b0011
) (
    input  logic        inClk,
    input  logic        inReset,
    input  logic [11:0] inSample,
    input  logic        inSampleReady,
    output logic        outDacCs,
    output logic        outDacSck,
    output logic        outDacSdi,
    output logic        outDacLdac,
    output logic        outBusy,
    output logic        outOverrun
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned BIT_W   = 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // Strobe synchroniser and edge detect
    logic               sync1_q, sync2_q, sync2_d_q;
    logic               sync_valid_q;
    logic               armed_q;
    logic               det_c;
    logic               det_q;
    logic [FRAME_W-1:0] cap_word_q;

    // FSM state and datapath
    logic [1:0]         state_q, state_nx;
    logic [DIV_W-1:0]   div_q, div_nx;
    logic [BIT_W-1:0]   bit_q, bit_nx;
    logic               phase_q, phase_nx;
    logic [FRAME_W-1:0] shreg_q, shreg_nx;
    logic               pend_v_q, pend_v_nx;
    logic [FRAME_W-1:0] pend_w_q, pend_w_nx;
    logic               cs_q, cs_nx;
    logic               sck_q, sck_nx;
    logic               sdi_q, sdi_nx;
    logic               ldac_q, ldac_nx;
    logic               busy_q, busy_nx;
    logic               ovr_q, ovr_nx;
    logic               load_en;
    logic [FRAME_W-1:0] load_word;

    // Edge is suppressed until the synchronised strobe has been seen low after
    // reset, so a strobe held high across reset release does not fire.
    assign det_c = armed_q & sync2_q & ~sync2_d_q;

    // Synchroniser, edge detect and sample capture (capture happens at the edge D)
    always_ff @(posedge inClk) begin
        if (inReset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync2_d_q    <= 1'b0;
            sync_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            det_q        <= 1'b0;
            cap_word_q   <= '0;
        end else begin
            sync1_q      <= inSampleReady;
            sync2_q      <= sync1_q;
            sync2_d_q    <= sync2_q;
            sync_valid_q <= 1'b1;
            if (sync_valid_q && !sync1_q) begin
                armed_q <= 1'b1;
            end
            det_q <= det_c;
            if (det_c) begin
                cap_word_q <= {DAC_CONFIG, ~inSample[11], inSample[10:0]};
            end
        end
    end

    // State and output registers
    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            shreg_q  <= '0;
            pend_v_q <= 1'b0;
            pend_w_q <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_q   <= 1'b1;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            div_q    <= div_nx;
            bit_q    <= bit_nx;
            phase_q  <= phase_nx;
            shreg_q  <= shreg_nx;
            pend_v_q <= pend_v_nx;
            pend_w_q <= pend_w_nx;
            cs_q     <= cs_nx;
            sck_q    <= sck_nx;
            sdi_q    <= sdi_nx;
            ldac_q   <= ldac_nx;
            busy_q   <= busy_nx;
            ovr_q    <= ovr_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state_q;
        div_nx    = div_q;
        bit_nx    = bit_q;
        phase_nx  = phase_q;
        shreg_nx  = shreg_q;
        pend_v_nx = pend_v_q;
        pend_w_nx = pend_w_q;
        cs_nx     = 1'b1;
        sck_nx    = 1'b0;
        sdi_nx    = sdi_q;
        ldac_nx   = 1'b1;
        ovr_nx    = 1'b0;
        load_en   = 1'b0;
        load_word = cap_word_q;

        case (state_q)
            ST_IDLE: begin
                // Pending word has priority; a simultaneous new sample takes its slot.
                if (pend_v_q) begin
                    load_en   = 1'b1;
                    load_word = pend_w_q;
                    pend_v_nx = det_q;
                    if (det_q) begin
                        pend_w_nx = cap_word_q;
                    end
                end else if (det_q) begin
                    load_en = 1'b1;
                end
            end
            ST_SHIFT: begin
                cs_nx  = 1'b0;
                sck_nx = sck_q;
                if (div_q == DIV_LAST) begin
                    div_nx = '0;
                    if (!phase_q) begin
                        phase_nx = 1'b1;
                        sck_nx   = 1'b1;
                    end else if (bit_q == '0) begin
                        state_nx = ST_TAIL;
                        phase_nx = 1'b0;
                        sck_nx   = 1'b0;
                    end else begin
                        // SCK falling edge: present the next bit while SCK is low
                        bit_nx   = BIT_W'(bit_q - 1'b1);
                        phase_nx = 1'b0;
                        sck_nx   = 1'b0;
                        shreg_nx = {shreg_q[FRAME_W-2:0], 1'b0};
                        sdi_nx   = shreg_q[FRAME_W-2];
                    end
                end else begin
                    div_nx = DIV_W'(div_q + 1'b1);
                end
            end
            ST_TAIL: begin
                cs_nx = 1'b0;
                if (div_q == DIV_LAST) begin
                    div_nx   = '0;
                    state_nx = ST_LATCH;
                    cs_nx    = 1'b1;
                    ldac_nx  = 1'b0;
                end else begin
                    div_nx = DIV_W'(div_q + 1'b1);
                end
            end
            ST_LATCH: begin
                ldac_nx = 1'b0;
                if (div_q == DIV_LAST) begin
                    div_nx   = '0;
                    state_nx = ST_IDLE;
                    ldac_nx  = 1'b1;
                end else begin
                    div_nx = DIV_W'(div_q + 1'b1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (load_en) begin
            state_nx = ST_SHIFT;
            div_nx   = '0;
            bit_nx   = BIT_W'(FRAME_W - 1);
            phase_nx = 1'b0;
            shreg_nx = load_word;
            cs_nx    = 1'b0;
            sck_nx   = 1'b0;
            sdi_nx   = load_word[FRAME_W-1];
        end

        // Sample arriving during a frame goes to the holding register
        if (det_q && (state_q != ST_IDLE)) begin
            ovr_nx    = pend_v_q;
            pend_v_nx = 1'b1;
            pend_w_nx = cap_word_q;
        end

        busy_nx = (state_nx != ST_IDLE);
    end

    assign outDacCs   = cs_q;
    assign outDacSck  = sck_q;
    assign outDacSdi  = sdi_q;
    assign outDacLdac = ldac_q;
    assign outBusy    = busy_q;
    assign outOverrun = ovr_q;

endmodule
